// File: rtl/an_dec_pkg.sv
// Shared types for the sequential AN-code decoder: result status codes, FSM states
// and the 2p mod A step used to walk the powers of two during the error search.
package an_dec_pkg;

    typedef enum logic [1:0] {
        ST_CLEAN   = 2'd0,
        ST_CORR_HL = 2'd1,
        ST_CORR_LH = 2'd2,
        ST_UNCORR  = 2'd3
    } an_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV1,
        S_SRCH,
        S_DIV2,
        S_OUT
    } an_state_e;

    // p < a is assumed, so a single conditional subtract keeps the result reduced.
    function automatic int unsigned dbl_mod(input int unsigned p, input int unsigned a);
        int unsigned d;
        d = p << 1;
        return (d >= a) ? d - a : d;
    endfunction

endpackage

// File: rtl/an_serial_div.sv
// Bit-serial restoring divider by the constant A: one quotient bit per cycle, MSB first.
// The start cycle already consumes the first bit, so a full word takes CW_W cycles.
module an_serial_div #(
    parameter int A    = 29,
    parameter int CW_W = 28,
    parameter int Q_W  = 23
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       start,
    input  logic [CW_W-1:0]            word,
    output logic [Q_W-1:0]             quot,
    output logic [$clog2(A+1)-1:0]     rem,
    output logic                       done
);

    localparam int A_W   = $clog2(A+1);
    localparam int CNT_W = $clog2(CW_W+1);
    localparam logic [A_W:0] A_V = (A_W+1)'(A);

    logic [A_W-1:0]  r;
    logic [CW_W-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic            run;

    logic            in_bit;
    logic [A_W:0]    trial;
    logic            qbit;
    logic [A_W-1:0]  r_nx;

    always_comb begin
        in_bit = start ? word[CW_W-1] : sh[CW_W-1];
        trial  = start ? {{A_W{1'b0}}, in_bit} : {r, in_bit};
        qbit   = (trial >= A_V);
        r_nx   = qbit ? A_W'(trial - A_V) : trial[A_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            sh   <= '0;
            quot <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (clr) begin
            r    <= '0;
            sh   <= '0;
            quot <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            r    <= r_nx;
            sh   <= word << 1;
            quot <= {{(Q_W-1){1'b0}}, qbit};
            cnt  <= CNT_W'(1);
            run  <= (CW_W > 1);
            done <= (CW_W == 1);
        end else if (run) begin
            r    <= r_nx;
            sh   <= sh << 1;
            quot <= {quot[Q_W-2:0], qbit};
            cnt  <= cnt + 1'b1;
            if (cnt == CNT_W'(CW_W-1)) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign rem = r;

endmodule

// File: rtl/an_decoder_seq.sv
// Sequential AN-code decoder: syndrome by serial division, single 1->0 error search, re-divide.
// Define ANDEC_BIDIR_EN to also search for and correct single 0->1 errors.
module an_decoder_seq
    import an_dec_pkg::*;
#(
    parameter  int A     = 29,
    parameter  int CW_W  = 28,
    localparam int A_W   = $clog2(A+1),
    localparam int N_W   = CW_W - A_W,
    localparam int POS_W = $clog2(CW_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_W-1:0]   out_data,
    output logic [1:0]       out_status,
    output logic [POS_W-1:0] out_pos
);

    localparam logic [A_W-1:0] A_V = A_W'(A);

    an_state_e        state, state_nx;
    an_status_e       corr_st, fix_st, res_st;
    logic [CW_W-1:0]  cw_reg, cw_fix, div_word;
    logic [N_W-1:0]   div_quot;
    logic [A_W-1:0]   div_rem, srch_p, srch_p_nx;
    logic [POS_W-1:0] srch_i, corr_pos, res_pos;
    logic             kick, accept, div_start, div_done;
    logic             hl_hit, lh_hit;
    logic             srch_init, srch_step, fix_en, ld_res;

    assign accept    = (state == S_IDLE) && in_valid;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);

    assign cw_fix    = cw_reg ^ (CW_W'(1) << srch_i);
    assign div_word  = (state == S_SRCH) ? cw_fix : cw_reg;
    assign srch_p_nx = A_W'(dbl_mod(32'(srch_p), int'(A)));

    // A 1->0 flip at bit i leaves a syndrome of -2^i mod A, i.e. A - p.
    assign hl_hit = ((A_V - srch_p) == div_rem) && !cw_reg[srch_i];
`ifdef ANDEC_BIDIR_EN
    assign lh_hit = (srch_p == div_rem) && cw_reg[srch_i];
`else
    assign lh_hit = 1'b0;
`endif

    an_serial_div #(
        .A    (A),
        .CW_W (CW_W),
        .Q_W  (N_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .start (div_start),
        .word  (div_word),
        .quot  (div_quot),
        .rem   (div_rem),
        .done  (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        div_start = kick;
        srch_init = 1'b0;
        srch_step = 1'b0;
        fix_en    = 1'b0;
        fix_st    = ST_CORR_HL;
        ld_res    = 1'b0;
        res_st    = ST_CLEAN;
        res_pos   = '0;
        case (state)
            S_IDLE: if (in_valid) state_nx = S_DIV1;
            S_DIV1: if (div_done) begin
                if (div_rem == '0) begin
                    state_nx = S_OUT;
                    ld_res   = 1'b1;
                end else begin
                    state_nx  = S_SRCH;
                    srch_init = 1'b1;
                end
            end
            // HL is tested ahead of LH so equal-i aliases resolve the same way every time.
            S_SRCH: begin
                if (hl_hit) begin
                    state_nx  = S_DIV2;
                    div_start = 1'b1;
                    fix_en    = 1'b1;
                end else if (lh_hit) begin
                    state_nx  = S_DIV2;
                    div_start = 1'b1;
                    fix_en    = 1'b1;
                    fix_st    = ST_CORR_LH;
                end else if (srch_i == POS_W'(CW_W-1)) begin
                    state_nx = S_OUT;
                    ld_res   = 1'b1;
                    res_st   = ST_UNCORR;
                end else begin
                    srch_step = 1'b1;
                end
            end
            S_DIV2: if (div_done) begin
                state_nx = S_OUT;
                ld_res   = 1'b1;
                if (div_rem == '0) begin
                    res_st  = corr_st;
                    res_pos = corr_pos;
                end else begin
                    res_st  = ST_UNCORR;
                end
            end
            S_OUT: if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kick       <= 1'b0;
            cw_reg     <= '0;
            srch_i     <= '0;
            srch_p     <= '0;
            corr_st    <= ST_CLEAN;
            corr_pos   <= '0;
            out_data   <= '0;
            out_status <= '0;
            out_pos    <= '0;
        end else begin
            kick <= accept;
            if (accept)      cw_reg <= in_cw;
            else if (fix_en) cw_reg <= cw_fix;
            if (srch_init) begin
                srch_i <= '0;
                srch_p <= A_W'(1);
            end else if (srch_step) begin
                srch_i <= srch_i + 1'b1;
                srch_p <= srch_p_nx;
            end
            if (fix_en) begin
                corr_st  <= fix_st;
                corr_pos <= srch_i;
            end
            if (ld_res) begin
                out_data   <= div_quot;
                out_status <= res_st;
                out_pos    <= res_pos;
            end
        end
    end

endmodule

// File: doc/an_decoder_seq.md
# an_decoder_seq

Parametrised, sequential AN-code decoder: accepts a CW_W-bit AN codeword (data × A) over a valid/ready handshake and returns the decoded data word plus an error status. Computes the syndrome (codeword mod A), locates a single unidirectional high-to-low (1→0) bit error by iterative search of 2^i mod A, corrects it, and divides by A with a bit-serial divider. It replaces the fixed combinational per-modulus decoders, at the cost of multi-cycle latency and no large combinational divider.

## Interface
- A, default 29: code modulus, odd, ≥3; 2 should have order ≥ CW_W mod A for full single-error coverage.
- CW_W, default 28: codeword width.
- Derived localparams (not overridable): A_W = $clog2(A+1) (5); N_W = CW_W − A_W (23); POS_W = $clog2(CW_W) (5).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  codeword offered.
- in_ready  out  1  decoder idle, can accept.
- in_cw  in  CW_W  received codeword.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  N_W  decoded data (quotient, truncated to N_W).
- out_status  out  2  0 CLEAN, 1 CORR_HL, 2 CORR_LH, 3 UNCORR.
- out_pos  out  POS_W  corrected bit index; 0 when CLEAN/UNCORR.

## Operation
- States: IDLE → DIV1 → (OUT | SRCH) ; SRCH → (DIV2 | OUT) ; DIV2 → OUT ; OUT → IDLE.
- IDLE: in_ready=1. in_valid&&in_ready latches in_cw into cw_reg, clears divider, enters DIV1.
- DIV1: restoring division of cw_reg by A, MSB first, one bit per cycle, CW_W cycles. Remainder register A_W+1 bits: r = {r,bit}; if r ≥ A then r −= A, qbit=1. Final r = syndrome s.
- s==0 → OUT, status CLEAN, data = DIV1 quotient.
- SRCH: i from 0, p from 1; per cycle p_next = 2p ≥ A ? 2p−A : 2p. HL match: (A−p)==s and cw_reg[i]==0 → cw_reg[i]←1, status CORR_HL, pos=i, go DIV2. Candidates failing the bit check are skipped; search continues.
- No match by i==CW_W−1 → OUT, status UNCORR, data = DIV1 quotient (floor), pos=0.
- Search order is strictly ascending i; first valid match wins.
- DIV2: same divider on the corrected word, CW_W cycles → OUT. Non-zero DIV2 remainder overrides status to UNCORR (pos 0).
- OUT: out_valid=1; out_data/out_status/out_pos stable until out_valid&&out_ready, then IDLE. in_ready=0 in every state except IDLE.
- Reset (any state, asynchronous): state IDLE, in_ready=1 after deassert, out_valid=0, out_data=0, out_status=0, out_pos=0, all counters/datapath registers 0. In-flight word discarded.

## Timing
- Acceptance edge = cycle 0. CLEAN: out_valid from cycle CW_W+1 (29 for defaults).
- CORR at bit i: out_valid from cycle 2·CW_W+i+2.
- UNCORR: out_valid from cycle 2·CW_W+1.
- One word in flight; next acceptance no earlier than the cycle after the out handshake.
- out_ready held low: outputs held indefinitely, no loss.

## Configuration
- ANDEC_BIDIR_EN defined: SRCH also tests LH match: p==s and cw_reg[i]==1 → cw_reg[i]←0, status CORR_LH. At equal i, HL is tested before LH. The choice of A must make ±2^i mod A distinct; otherwise the lowest-i rule resolves aliases deterministically.
- Undefined: LH logic absent; status 2 never produced.

## Structure
- Package an_dec_pkg: status enum (CLEAN/CORR_HL/CORR_LH/UNCORR), state enum, function for 2p mod A step.
- Sub-module an_serial_div: bit-serial restoring divider (start, load word, CW_W-cycle run, quotient, remainder, done), instantiated once, reused for DIV1 and DIV2.

## Test plan
- in_cw=29000 (data 1000) → out_data=1000, CLEAN, pos 0, out_valid at cycle 29.
- in_cw=28992 (bit 3 cleared, s=21) → out_data=1000, CORR_HL, pos 3, out_valid at cycle 61.
- in_cw=12616 (bit 14 cleared, s=1) → out_data=1000, CORR_HL, pos 14.
- in_cw=28928 (bits 3,6 cleared, s=15; candidate bit 13 is 1) → UNCORR, pos 0, out_data=997.
- ANDEC_BIDIR_EN: in_cw=29001 (s=1) → LH at i=0 precedes HL at i=14 → out_data=1000, CORR_LH, pos 0.
- rst_n pulsed low mid-DIV2 with out_ready=0 backpressure in prior result → all outputs 0, in_ready=1; next word 29000 decodes CLEAN normally.
